// File: rtl/uart_tx_scheduler.sv
// Packet-granular round-robin scheduler in front of a single uart byte transmitter.
// Optional per-byte watchdog: define UART_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYC = 16,
  parameter int TMO_CYC = 4096
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_len,
  input  logic [NUM_REQ*8-1:0] req_byte,
  output logic [NUM_REQ-1:0]   byte_ack,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 transmit,
  output logic [7:0]           tx_byte,
  input  logic                 is_transmitting
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYC < 0 || GAP_CYC > 255 || TMO_CYC < 1) begin : g_bad_param
    $error("uart_tx_scheduler: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_HI, WAIT_LO, GAP
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        g_q, g_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           gap_q, gap_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 transmit_q, transmit_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [IW-1:0]        pick;
  logic                 pick_vld;

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] v);
    return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  // Round-robin pick: first pending request at or above the rr pointer, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick     = rr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_q) + k) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick     = IW'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  // Next-state logic; byte/done/transmit strobes default low every cycle.
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    rr_d       = rr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    tx_byte_d  = tx_byte_q;
    transmit_d = 1'b0;
    ack_d      = '0;
    done_d     = '0;
`ifdef UART_SCHED_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          g_d   = pick;
          len_d = req_len[int'(pick)*8 +: 8];
          if (req_len[int'(pick)*8 +: 8] == 8'd0) begin
            done_d[pick] = 1'b1;
            rr_d         = nxt(pick);
            state_d      = GAP;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        tx_byte_d  = req_byte[int'(g_q)*8 +: 8];
        ack_d[g_q] = 1'b1;
        cnt_d      = cnt_q + 8'd1;
        state_d    = START;
      end
      START: begin
        if (!is_transmitting) begin
          transmit_d = 1'b1;
          state_d    = WAIT_HI;
`ifdef UART_SCHED_TIMEOUT_EN
          tmo_d      = '0;
`endif
        end
      end
      WAIT_HI: begin
        if (is_transmitting) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!is_transmitting) begin
          if (cnt_q == len_q) begin
            done_d[g_q] = 1'b1;
            rr_d        = nxt(g_q);
            state_d     = GAP;
          end else begin
            state_d = LOAD;
          end
        end
      end
      GAP: begin
        if (int'(gap_q) + 1 >= GAP_CYC) begin
          gap_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_SCHED_TIMEOUT_EN
    if (state_q == WAIT_HI || state_q == WAIT_LO) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_q == TW'(TMO_CYC - 1)) begin
        err_d       = 1'b1;
        done_d      = '0;
        done_d[g_q] = 1'b1;
        rr_d        = nxt(g_q);
        state_d     = GAP;
      end
    end
`endif
  end

  // State and registered outputs; reset aborts any packet without a done.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      g_q        <= '0;
      rr_q       <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      tx_byte_q  <= '0;
      transmit_q <= 1'b0;
      ack_q      <= '0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      rr_q       <= rr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      tx_byte_q  <= tx_byte_d;
      transmit_q <= transmit_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
    end
  end

`ifdef UART_SCHED_TIMEOUT_EN
  // Per-byte watchdog counter and sticky error flag.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign busy     = (state_q != IDLE);
  assign transmit = transmit_q;
  assign tx_byte  = tx_byte_q;
  assign byte_ack = ack_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: queued requesters, a uart stand-in,
// and an event-order reference model of packet-level round robin.
module tb_uart_tx_scheduler;

  localparam int N   = 4;
  localparam int GAP = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*8-1:0] req_len = '0;
  logic [N*8-1:0] req_byte = '0;
  logic [N-1:0]   byte_ack, done;
  logic           busy, timeout_err, transmit;
  logic [7:0]     tx_byte;
  logic           itx = 1'b0;

  uart_tx_scheduler #(.NUM_REQ(N), .GAP_CYC(GAP), .TMO_CYC(4096)) dut (
    .sys_clk(clk), .rst(rst), .req(req), .req_len(req_len),
    .req_byte(req_byte), .byte_ack(byte_ack), .done(done),
    .busy(busy), .timeout_err(timeout_err), .transmit(transmit),
    .tx_byte(tx_byte), .is_transmitting(itx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         dn;
    int         who;
    logic [7:0] b;
  } ev_t;

  logic [7:0] data [N][4][256];
  int   lens [N][4];
  int   npk [N];
  int   pk_i [N];
  int   bi [N];
  bit   jd [N];
  ev_t  eq [$];
  ev_t  ev;
  int   m_rr = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   tx_count = 0;
  int   t_req = -1, t_tx = -1, t_done = -1, t_idle = -1;
  int   dur_fix = 10;
  bit   dur_rand = 0;
  bit   u_pend = 0;
  int   u_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Packet-level round robin: every listed packet is pending from the start.
  function automatic void build_model();
    int pend [N];
    int g, p;
    for (int i = 0; i < N; i++) pend[i] = npk[i] - pk_i[i];
    while (1) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && pend[(m_rr + k) % N] > 0) g = (m_rr + k) % N;
      end
      if (g < 0) break;
      p = npk[g] - pend[g];
      for (int b = 0; b < lens[g][p]; b++)
        eq.push_back('{dn: 1'b0, who: g, b: data[g][p][b]});
      eq.push_back('{dn: 1'b1, who: g, b: 8'h00});
      pend[g]--;
      m_rr = (g + 1) % N;
    end
  endfunction

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      npk[i] = 0; pk_i[i] = 0; bi[i] = 0;
    end
  endtask

  // Monitor, requesters and uart stand-in, all sampled/driven at negedge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (transmit) begin
        tx_count++;
        if (t_tx < 0) t_tx = cyc;
        chk("uart_free", {31'b0, itx | u_pend}, 0);
        if (eq.size() == 0) chk("tx_extra", 1, 0);
        else begin
          ev = eq.pop_front();
          chk("tx_kind", {31'b0, ev.dn}, 0);
          chk($sformatf("tx_byte_r%0d", ev.who), {24'b0, tx_byte}, {24'b0, ev.b});
        end
      end
      if (byte_ack != '0) begin
        if (eq.size() == 0 || eq[0].dn) chk("ack_extra", {28'b0, byte_ack}, 0);
        else chk("ack_owner", {28'b0, byte_ack}, 32'd1 << eq[0].who);
      end
      if (done != '0) begin
        if (t_done < 0) t_done = cyc;
        if (eq.size() == 0) chk("done_extra", {28'b0, done}, 0);
        else begin
          ev = eq.pop_front();
          chk("done_kind", {31'b0, ev.dn}, 1);
          chk("done_owner", {28'b0, done}, 32'd1 << ev.who);
        end
      end
      if (t_done >= 0 && t_idle < 0 && cyc > t_done && !busy) t_idle = cyc;
      for (int i = 0; i < N; i++) begin
        jd[i] = 1'b0;
        if (done[i]) begin
          pk_i[i]++; bi[i] = 0; req[i] = 1'b0; jd[i] = 1'b1;
        end else if (byte_ack[i]) begin
          bi[i]++;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!req[i] && !jd[i] && pk_i[i] < npk[i]) begin
          req[i] = 1'b1;
          if (t_req < 0) t_req = cyc;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      req_len[i*8 +: 8]  = 8'(lens[i][pk_i[i] > 3 ? 3 : pk_i[i]]);
      req_byte[i*8 +: 8] = data[i][pk_i[i] > 3 ? 3 : pk_i[i]][bi[i] > 255 ? 255 : bi[i]];
    end
    if (u_pend) begin
      itx = 1'b1; u_pend = 1'b0;
      u_cnt = dur_rand ? int'($urandom_range(1, 12)) : dur_fix;
    end else if (itx) begin
      u_cnt--;
      if (u_cnt <= 0) itx = 1'b0;
    end
    if (transmit && !rst) u_pend = 1'b1;
  end

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; req = '0; eq.delete(); m_rr = 0; clear_reqs();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_wait(input int limit);
    bit ok;
    bit fin;
    ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      @(negedge clk); #1;
      fin = 1'b1;
      for (int i = 0; i < N; i++) if (pk_i[i] != npk[i]) fin = 1'b0;
      if (fin && eq.size() == 0 && !busy) ok = 1'b1;
    end
    chk("run_complete", {31'b0, ok}, 1);
    chk("events_left", eq.size(), 0);
    chk("timeout_err", {31'b0, timeout_err}, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 4; p++) begin
        lens[i][p] = 0;
        for (int b = 0; b < 256; b++) data[i][p][b] = 8'h00;
      end
    clear_reqs();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_transmit", {31'b0, transmit}, 0);
    chk("rst_done", {28'b0, done}, 0);
    chk("rst_ack", {28'b0, byte_ack}, 0);
    chk("rst_tx_byte", {24'b0, tx_byte}, 0);
    chk("rst_tmo", {31'b0, timeout_err}, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("idle_busy", {31'b0, busy}, 0);

    // single 3-byte packet from requester 1, uart busy 10 cycles per byte
    clear_reqs();
    lens[1][0] = 3;
    data[1][0][0] = 8'hA1; data[1][0][1] = 8'hA2; data[1][0][2] = 8'hA3;
    dur_rand = 0; dur_fix = 10; tx_count = 0;
    t_req = -1; t_tx = -1; t_done = -1; t_idle = -1;
    npk[1] = 1;
    build_model();
    run_wait(2000);
    chk("lat_req_tx", t_tx - t_req, 3);
    chk("gap_len", t_idle - t_done, GAP);
    chk("t1_tx_count", tx_count, 3);

    // all four requesters, 2-byte packets, requester 0 twice
    do_reset();
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 2; p++) begin
        lens[i][p] = 2;
        for (int b = 0; b < 2; b++) data[i][p][b] = 8'(16 * i + 4 * p + b + 1);
      end
    dur_fix = 4; tx_count = 0;
    npk[0] = 2; npk[1] = 1; npk[2] = 1; npk[3] = 1;
    build_model();
    run_wait(4000);
    chk("t2_tx_count", tx_count, 10);

    // zero-length packet
    clear_reqs();
    lens[2][0] = 0; tx_count = 0;
    npk[2] = 1;
    build_model();
    run_wait(500);
    chk("t3_tx_count", tx_count, 0);

    // 255-byte packet
    clear_reqs();
    lens[0][0] = 255;
    for (int b = 0; b < 256; b++) data[0][0][b] = 8'($urandom);
    dur_fix = 2; tx_count = 0;
    npk[0] = 1;
    build_model();
    run_wait(20000);
    chk("t6_tx_count", tx_count, 255);

    // reset while waiting on byte 2 of a 5-byte packet
    do_reset();
    lens[2][0] = 5;
    for (int b = 0; b < 5; b++) data[2][0][b] = 8'($urandom);
    dur_fix = 10; tx_count = 0;
    npk[2] = 1;
    build_model();
    for (int k = 0; k < 200 && tx_count < 2; k++) begin
      @(negedge clk); #1;
    end
    chk("t4_reached_b2", tx_count, 2);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t4_busy", {31'b0, busy}, 0);
    chk("t4_transmit", {31'b0, transmit}, 0);
    chk("t4_ack", {28'b0, byte_ack}, 0);
    chk("t4_done", {28'b0, done}, 0);
    chk("t4_tx_byte", {24'b0, tx_byte}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    eq.delete(); req = '0; m_rr = 0;
    pk_i[2] = 0; bi[2] = 0; tx_count = 0;
    build_model();
    rst = 1'b0;
    run_wait(2000);
    chk("t4_resend_count", tx_count, 5);

    // randomized rounds
    dur_rand = 1;
    for (int r = 0; r < 6; r++) begin
      clear_reqs();
      for (int i = 0; i < N; i++)
        for (int p = 0; p < 3; p++) begin
          lens[i][p] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
          for (int b = 0; b < 8; b++) data[i][p][b] = 8'($urandom);
        end
      for (int i = 0; i < N; i++) npk[i] = int'($urandom_range(0, 3));
      build_model();
      run_wait(20000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
